// File: rtl/move_scheduler_if.sv
// Handshake bundle between the SPI message FSM (push side), the move scheduler
// and the step generator (move side).
interface move_scheduler_if;
  logic        push_valid;
  logic        push_ready;
  logic        push_dir;
  logic [63:0] push_duration;
  logic [63:0] push_increment;
  logic [63:0] push_incinc;
  logic        move_start;
  logic        move_dir;
  logic [63:0] move_duration;
  logic [63:0] move_increment;
  logic [63:0] move_incinc;
  logic        move_done;

  // Environment side: presents commands and reports move completion.
  modport master (
    output push_valid, push_dir, push_duration, push_increment, push_incinc, move_done,
    input  push_ready, move_start, move_dir, move_duration, move_increment, move_incinc
  );

  // Scheduler side.
  modport slave (
    input  push_valid, push_dir, push_duration, push_increment, push_incinc, move_done,
    output push_ready, move_start, move_dir, move_duration, move_increment, move_incinc
  );
endinterface

// File: rtl/move_scheduler.sv
// Buffers coordinated-move commands in a DEPTH-entry FIFO and issues them back-to-back
// to the step generator. Optional queue flush / abort enabled by MOVE_SCHEDULER_FLUSH_EN.
module move_scheduler #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic            CLK,
  input  logic            reset,
  move_scheduler_if.slave bus,
  output logic            busy,
  output logic [CW-1:0]   queue_count,
  output logic            fault
`ifdef MOVE_SCHEDULER_FLUSH_EN
  ,
  input  logic            flush,
  output logic            move_abort
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic        dir;
    logic [63:0] duration;
    logic [63:0] increment;
    logic [63:0] incinc;
  } move_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  move_t         mem [DEPTH];
  move_t         head;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          flush_s;
  logic          push_fire;
  logic          queue_empty;
  logic          pop;
  logic          fault_set;

`ifdef MOVE_SCHEDULER_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  // Readiness comes only from registered occupancy, so a same-cycle pop never frees a slot.
  assign bus.push_ready = (queue_count < CW'(DEPTH)) && !reset && !flush_s;
  assign push_fire      = bus.push_valid && bus.push_ready;
  assign queue_empty    = (queue_count == '0);
  assign head           = mem[rd_ptr];
  assign busy           = (state == ST_RUN);

  // State register.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    if (flush_s) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: if (!queue_empty)              state_nxt = ST_RUN;
        ST_RUN:  if (bus.move_done && queue_empty) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Control decode: when to pop the head into move_* and when a done is stray.
  always_comb begin
    pop       = 1'b0;
    fault_set = 1'b0;
    if (!flush_s) begin
      unique case (state)
        ST_IDLE: begin
          pop       = !queue_empty;
          fault_set = bus.move_done;
        end
        ST_RUN:  pop = bus.move_done && !queue_empty;
        default: pop = 1'b0;
      endcase
    end
  end

  // FIFO storage; no reset needed since occupancy gates every read.
  always_ff @(posedge CLK) begin
    if (push_fire) begin
      mem[wr_ptr] <= '{dir:       bus.push_dir,
                       duration:  bus.push_duration,
                       increment: bus.push_increment,
                       incinc:    bus.push_incinc};
    end
  end

  // Pointers, occupancy and the registered move outputs.
  always_ff @(posedge CLK) begin
    if (reset) begin
      rd_ptr             <= '0;
      wr_ptr             <= '0;
      queue_count        <= '0;
      fault              <= 1'b0;
      bus.move_start     <= 1'b0;
      bus.move_dir       <= 1'b0;
      bus.move_duration  <= '0;
      bus.move_increment <= '0;
      bus.move_incinc    <= '0;
    end else begin
      bus.move_start <= pop;
      if (fault_set) begin
        fault <= 1'b1;
      end
      if (flush_s) begin
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        queue_count <= '0;
      end else begin
        if (push_fire) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr             <= rd_ptr + AW'(1);
          bus.move_dir       <= head.dir;
          bus.move_duration  <= head.duration;
          bus.move_increment <= head.increment;
          bus.move_incinc    <= head.incinc;
        end
        queue_count <= queue_count + CW'(push_fire) - CW'(pop);
      end
    end
  end

`ifdef MOVE_SCHEDULER_FLUSH_EN
  // Abort pulse tells the step generator its in-flight move was cancelled.
  always_ff @(posedge CLK) begin
    if (reset) begin
      move_abort <= 1'b0;
    end else begin
      move_abort <= flush && (state == ST_RUN);
    end
  end
`endif

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler with a queue-based reference model checked every cycle.
module tb_move_scheduler;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic          CLK = 1'b0;
  logic          reset;
  logic          busy;
  logic [CW-1:0] queue_count;
  logic          fault;
`ifdef MOVE_SCHEDULER_FLUSH_EN
  logic          flush;
  logic          move_abort;
`endif

  move_scheduler_if bus();

  move_scheduler #(.DEPTH(DEPTH)) dut (
    .CLK         (CLK),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .queue_count (queue_count),
    .fault       (fault)
`ifdef MOVE_SCHEDULER_FLUSH_EN
    ,
    .flush       (flush),
    .move_abort  (move_abort)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        dir;
    logic [63:0] dur;
    logic [63:0] inc;
    logic [63:0] incinc;
  } mv_t;

  mv_t m_q[$];
  mv_t m_cur;
  bit  m_busy, m_start, m_fault, m_abort;
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit flush_now();
`ifdef MOVE_SCHEDULER_FLUSH_EN
    return flush;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: a plain queue plus "current move" and running flag.
  always @(posedge CLK) begin
    bit acc;
    if (reset) begin
      m_q.delete();
      m_cur   = '{1'b0, 64'd0, 64'd0, 64'd0};
      m_busy  = 0;
      m_start = 0;
      m_fault = 0;
      m_abort = 0;
    end else if (flush_now()) begin
      m_abort = m_busy;
      m_q.delete();
      m_busy  = 0;
      m_start = 0;
    end else begin
      m_abort = 0;
      m_start = 0;
      acc = bus.push_valid && (m_q.size() < DEPTH);
      if (!m_busy) begin
        if (bus.move_done) m_fault = 1;
        if (m_q.size() > 0) begin
          m_cur   = m_q.pop_front();
          m_start = 1;
          m_busy  = 1;
        end
      end else if (bus.move_done) begin
        if (m_q.size() > 0) begin
          m_cur   = m_q.pop_front();
          m_start = 1;
        end else begin
          m_busy = 0;
        end
      end
      if (acc) m_q.push_back('{bus.push_dir, bus.push_duration, bus.push_increment, bus.push_incinc});
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge CLK) begin
    chk("push_ready", 64'(bus.push_ready), 64'((m_q.size() < DEPTH) && !reset && !flush_now()));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("queue_count", 64'(queue_count), 64'(m_q.size()));
    chk("move_start", 64'(bus.move_start), 64'(m_start));
    chk("fault", 64'(fault), 64'(m_fault));
    chk("move_dir", 64'(bus.move_dir), 64'(m_cur.dir));
    chk("move_duration", bus.move_duration, m_cur.dur);
    chk("move_increment", bus.move_increment, m_cur.inc);
    chk("move_incinc", bus.move_incinc, m_cur.incinc);
`ifdef MOVE_SCHEDULER_FLUSH_EN
    chk("move_abort", 64'(move_abort), 64'(m_abort));
`endif
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_push(input mv_t m);
    bus.push_dir       = m.dir;
    bus.push_duration  = m.dur;
    bus.push_increment = m.inc;
    bus.push_incinc    = m.incinc;
  endtask

  task automatic push_one(input mv_t m);
    set_push(m);
    bus.push_valid = 1'b1;
    tick();
    bus.push_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (!busy && queue_count == 0) break;
      bus.move_done = busy;
      tick();
      bus.move_done = 1'b0;
    end
    chk("drain_busy", 64'(busy), 64'd0);
    chk("drain_count", 64'(queue_count), 64'd0);
  endtask

  mv_t vec [3];
  mv_t tmp;

  initial begin
    vec[0] = '{1'b0, 64'd5, 64'hFFFF_FFFF_FFFF_FFF0, 64'd3};
    vec[1] = '{1'b1, 64'd7, 64'd1234, 64'hFFFF_FFFF_FFFF_FFFE};
    vec[2] = '{1'b0, 64'd9, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF};

    reset          = 1'b1;
    bus.push_valid = 1'b0;
    bus.move_done  = 1'b0;
    set_push('{1'b0, 64'd0, 64'd0, 64'd0});
`ifdef MOVE_SCHEDULER_FLUSH_EN
    flush = 1'b0;
`endif
    tick();
    tick();
    chk("reset_push_ready", 64'(bus.push_ready), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_reset_push_ready", 64'(bus.push_ready), 64'd1);

    // Single move
    tmp = '{1'b1, 64'h10, 64'd100000000000, 64'd1000000000};
    push_one(tmp);
    chk("single_count_after_push", 64'(queue_count), 64'd1);
    chk("single_no_start_yet", 64'(bus.move_start), 64'd0);
    tick();
    chk("single_start", 64'(bus.move_start), 64'd1);
    chk("single_dir", 64'(bus.move_dir), 64'd1);
    chk("single_dur", bus.move_duration, 64'h10);
    chk("single_inc", bus.move_increment, 64'd100000000000);
    chk("single_incinc", bus.move_incinc, 64'd1000000000);
    chk("single_busy", 64'(busy), 64'd1);
    chk("single_count", 64'(queue_count), 64'd0);
    tick();
    chk("single_start_clears", 64'(bus.move_start), 64'd0);
    bus.move_done = 1'b1;
    tick();
    bus.move_done = 1'b0;
    chk("single_idle_after_done", 64'(busy), 64'd0);

    // Back-to-back
    for (int k = 0; k < 3; k++) push_one(vec[k]);
    for (int k = 0; k < 3; k++) begin
      tick();
      bus.move_done = 1'b1;
      tick();
      bus.move_done = 1'b0;
      if (k < 2) begin
        chk("b2b_start", 64'(bus.move_start), 64'd1);
        chk("b2b_dur", bus.move_duration, vec[k+1].dur);
      end
    end
    tick();
    chk("b2b_busy_end", 64'(busy), 64'd0);
    chk("b2b_count_end", 64'(queue_count), 64'd0);

    // Full queue with the generator held busy
    push_one(vec[0]);
    tick();
    chk("full_running", 64'(busy), 64'd1);
    bus.push_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tmp = '{i[0], 64'(32'h100 + i), 64'(i), 64'(i * 3)};
      set_push(tmp);
      tick();
      chk("full_fill_count", 64'(queue_count), 64'(i + 1));
    end
    tmp = '{1'b1, 64'hDEAD, 64'hBEEF, 64'hCAFE};
    set_push(tmp);
    chk("full_ready_low", 64'(bus.push_ready), 64'd0);
    tick();
    chk("full_count_held", 64'(queue_count), 64'd4);
    bus.move_done = 1'b1;
    tick();
    bus.move_done = 1'b0;
    bus.push_valid = 1'b0;
    chk("full_pop_no_push", 64'(queue_count), 64'd3);
    chk("full_next_dur", bus.move_duration, 64'h100);
    drain();

    // Stray done
    bus.move_done = 1'b1;
    tick();
    bus.move_done = 1'b0;
    chk("stray_fault", 64'(fault), 64'd1);
    chk("stray_no_start", 64'(bus.move_start), 64'd0);
    repeat (3) tick();
    chk("stray_fault_sticky", 64'(fault), 64'd1);

    // Reset mid-move
    for (int k = 0; k < 3; k++) push_one(vec[k]);
    chk("rst_mid_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_count", 64'(queue_count), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_start", 64'(bus.move_start), 64'd0);
    chk("rst_dur", bus.move_duration, 64'd0);
    reset = 1'b0;
    repeat (5) tick();
    chk("rst_no_start_after", 64'(bus.move_start), 64'd0);
    chk("rst_still_idle", 64'(busy), 64'd0);

`ifdef MOVE_SCHEDULER_FLUSH_EN
    // Flush during RUN with two queued, coincident push and done
    for (int k = 0; k < 3; k++) push_one(vec[k]);
    chk("flush_pre_count", 64'(queue_count), 64'd2);
    flush          = 1'b1;
    bus.push_valid = 1'b1;
    bus.move_done  = 1'b1;
    #1;
    chk("flush_push_ready", 64'(bus.push_ready), 64'd0);
    tick();
    flush          = 1'b0;
    bus.push_valid = 1'b0;
    bus.move_done  = 1'b0;
    chk("flush_abort", 64'(move_abort), 64'd1);
    chk("flush_count", 64'(queue_count), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_no_fault", 64'(fault), 64'd0);
    tick();
    chk("flush_abort_once", 64'(move_abort), 64'd0);
    chk("flush_no_start", 64'(bus.move_start), 64'd0);
    bus.move_done = 1'b1;
    tick();
    bus.move_done = 1'b0;
    chk("flush_done_idle_fault", 64'(fault), 64'd1);
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
